// File: rtl/adder_arbiter_if.sv
// Request/result bundle for the shared-adder arbiter.
// The arbiter takes the slave view; the requesters and result consumer take the master view.
interface adder_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_result;
  logic                      out_carry;
  logic [ID_W-1:0]           out_id;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_result, out_carry, out_id
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_result, out_carry, out_id
  );
endinterface

// File: rtl/adder_arbiter.sv
// One adder shared round-robin between NUM_REQ requesters.
// The result sits in a single-entry buffer that refills in the same cycle it drains.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input logic              clk,
  input logic              rst_n,
  adder_arbiter_if.slave   bus
);
  localparam int          ID_W = $clog2(NUM_REQ);
  localparam int unsigned N    = NUM_REQ;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic              grant_found;
  logic              can_accept;
  logic              xfer;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W:0]   sum;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % N);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign can_accept = !bus.out_valid || bus.out_ready;
  // rst_n gates the grant so nothing handshakes while reset is held.
  assign xfer       = grant_found && can_accept && rst_n;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (ID_W'(k) == grant_idx) begin
        a_sel = bus.req_a[k*DATA_W +: DATA_W];
        b_sel = bus.req_b[k*DATA_W +: DATA_W];
      end
    end
  end

  assign sum = {1'b0, a_sel} + {1'b0, b_sel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_carry  <= 1'b0;
      bus.out_id     <= '0;
      rr_ptr         <= '0;
    end else if (xfer) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= sum[DATA_W-1:0];
      bus.out_carry  <= sum[DATA_W];
      bus.out_id     <= grant_idx;
      if (32'(grant_idx) == N - 1) rr_ptr <= '0;
      else                         rr_ptr <= grant_idx + ID_W'(1);
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized scoreboard bench for adder_arbiter with a queue-based reference model.
module tb_adder_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    adder_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
    adder_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int unsigned id;
        logic [31:0] res;
        logic        carry;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned m_ptr = 0;
    bit          m_occ = 0;
    bit          fair_on = 0;
    int unsigned gap = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd_ops();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle of stimulus, compare the grant against the model, push the expected result.
    task automatic step(input logic [3:0] v, input logic ordy,
                        input logic [127:0] a, input logic [127:0] b);
        bit          found;
        int unsigned gi;
        int unsigned idx;
        logic [3:0]  exp_rdy;
        logic [32:0] s;
        exp_t        e;
        @(posedge clk);
        #1;
        bus.req_valid = v;
        bus.out_ready = ordy;
        bus.req_a = a;
        bus.req_b = b;
        #3;
        found = 0;
        gi = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (!found && v[idx]) begin
                found = 1;
                gi = idx;
            end
        end
        exp_rdy = (found && (!m_occ || ordy)) ? 4'(1 << gi) : 4'b0;
        chk("out_valid", 64'(bus.out_valid), 64'(m_occ));
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        if (fair_on && bus.req_ready != 4'b0) begin
            if (bus.req_ready[3]) gap = 0;
            else gap++;
            chk("fair_gap_le3", 64'(gap <= 3), 64'd1);
        end
        if (exp_rdy != 4'b0) begin
            s = {1'b0, a[gi*32 +: 32]} + {1'b0, b[gi*32 +: 32]};
            e.id = gi;
            e.res = s[31:0];
            e.carry = s[32];
            sb.push_back(e);
            m_ptr = (gi + 1) % NR;
            m_occ = 1;
        end else if (ordy) begin
            m_occ = 0;
        end
    endtask

    logic [31:0] h_res;
    logic        h_carry;
    logic [1:0]  h_id;
    bit          h_pend = 0;
    exp_t        got;

    // Monitor: pops on each consumed result and checks stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            h_pend = 0;
        end else begin
            if (h_pend) begin
                chk("hold_result", 64'(bus.out_result), 64'(h_res));
                chk("hold_carry", 64'(bus.out_carry), 64'(h_carry));
                chk("hold_id", 64'(bus.out_id), 64'(h_id));
            end
            h_pend = bus.out_valid && !bus.out_ready;
            h_res = bus.out_result;
            h_carry = bus.out_carry;
            h_id = bus.out_id;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual_id=%0d required=none", bus.out_id);
                end else begin
                    got = sb.pop_front();
                    chk("result", 64'(bus.out_result), 64'(got.res));
                    chk("carry", 64'(bus.out_carry), 64'(got.carry));
                    chk("id", 64'(bus.out_id), 64'(got.id));
                end
            end
        end
    end

    initial begin
        bus.req_valid = '1;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_out_carry", 64'(bus.out_carry), 64'd0);
        chk("rst_out_id", 64'(bus.out_id), 64'd0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        repeat (8) step(4'hF, 1'b1, rnd_ops(), rnd_ops());
        step(4'b0010, 1'b1, {32'd0, 32'd0, 32'd1, 32'd0}, {32'd0, 32'd0, 32'd2, 32'd0});
        step(4'b0001, 1'b1, {96'd0, 32'hFFFF_FFFF}, {96'd0, 32'h1});
        step(4'b0100, 1'b1, {32'd0, 32'h20, 64'd0}, {32'd0, 32'h4, 64'd0});

        step(4'hF, 1'b1, rnd_ops(), rnd_ops());
        repeat (3) step(4'hF, 1'b0, rnd_ops(), rnd_ops());
        repeat (4) step(4'hF, 1'b1, rnd_ops(), rnd_ops());

        fair_on = 1;
        gap = 0;
        repeat (40) step({1'b1, 3'($urandom)}, ($urandom_range(0, 3) != 0), rnd_ops(), rnd_ops());
        fair_on = 0;

        repeat (3) step(4'h0, 1'b1, rnd_ops(), rnd_ops());
        repeat (2) step(4'hF, 1'b1, rnd_ops(), rnd_ops());

        repeat (200) step(4'($urandom), ($urandom_range(0, 3) != 0), rnd_ops(), rnd_ops());

        step(4'hF, 1'b0, rnd_ops(), rnd_ops());
        step(4'hF, 1'b0, rnd_ops(), rnd_ops());
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_id", 64'(bus.out_id), 64'd0);
        chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
        sb.delete();
        m_occ = 0;
        m_ptr = 0;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(4'b1100, 1'b1, rnd_ops(), rnd_ops());

        repeat (3) step(4'h0, 1'b1, rnd_ops(), rnd_ops());
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 32-bit adder between NUM_REQ requesters, e.g. the PC-increment, branch-target and address-generation units.
- Arbitration is round-robin; requesters use a valid/ready handshake.
- The sum is registered in a single-entry output buffer with backpressure, tagged with the requester index and carry-out.
- Sits between the requesting datapath units and the shared adder resource, so replicated adders become one arbitrated instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ) is a derived localparam.
- DATA_W, 32, operand/result width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  bit i: requester i presents operands.
- req_a  input  NUM_REQ*DATA_W  operand A, requester i in bits [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  operand B, same packing.
- req_ready  output  NUM_REQ  one-hot-or-zero grant; transfer when req_valid[i] && req_ready[i].
- out_valid  output  1  output buffer holds a result.
- out_ready  input  1  consumer accepts result this cycle.
- out_result  output  DATA_W  (A+B) mod 2^DATA_W.
- out_carry  output  1  carry-out, bit DATA_W of A+B.
- out_id  output  ID_W  index of the requester that produced the result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: out_valid=0, out_result=0, out_carry=0, out_id=0, rr_ptr=0.
  - Reset asserted mid-operation discards any buffered result.
  - No req_ready is asserted while rst_n=0.
- can_accept = !out_valid || out_ready. The buffer is refilled in the same cycle it drains, so full throughput is 1 op/cycle.
- Grant selection (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - The first i with req_valid[i]=1 is the grant.
  - req_ready[i]=1 only for the granted i, and only when can_accept.
  - All zero when no valid request or !can_accept.
- req_ready depends on req_valid and out_ready combinationally. There is no path from req_a/req_b to req_ready.
- On transfer (granted i, can_accept):
  - Next edge: out_result <= A_i+B_i truncated, out_carry <= carry, out_id <= i, out_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Latency: accepted at edge t, result visible after edge t with out_valid=1 (1 cycle).
- Drain with no new transfer: out_valid <= 0. out_result, out_carry and out_id keep their last values.
- Backpressure: while out_valid && !out_ready, out_result, out_carry and out_id are held stable and all req_ready are 0.
- rr_ptr changes only on a transfer. Idle cycles and stalls leave it unchanged.
- A requester deasserting req_valid before transfer is allowed. The grant moves to the next valid requester in the same cycle, with no penalty.
- Fairness: a continuously valid requester is granted within NUM_REQ transfers.
- Wrap-around: 32'hFFFFFFFF + 32'h00000001 gives out_result=0, out_carry=1. No overflow flag; signed overflow is the consumer's job.
- Only the granted requester's operands are sampled. Others are don't-care.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_id=0, req_ready=0 immediately (asynchronous). After release, first grant goes to lowest valid index ≥0.
- Single requester: req_valid=4'b0010, A=1, B=2, out_ready=1 -> req_ready=4'b0010, next cycle out_valid=1, out_result=3, out_id=1, out_carry=0.
- Round robin: all four valid continuously, out_ready=1 -> grants 0,1,2,3,0,... one per cycle. out_id sequence matches, one result per cycle.
- Backpressure: out_ready=0 for 3 cycles with all valid -> req_ready=0, out_* stable for 3 cycles. On out_ready=1, the drain and the next grant happen in the same cycle, and rr_ptr continues from its stored value.
- Carry / wrap: A=32'hFFFFFFFF, B=32'h00000001 -> out_result=0, out_carry=1. A=32'h00000020, B=32'h00000004 -> 32'h24, out_carry=0.
- Fairness: requester 3 held valid while 0..2 toggle randomly -> requester 3 granted within every 4 transfers.
- Idle: no requests -> rr_ptr unchanged.
